// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronised line, OVERSAMPLE x ticks per bit, mid-bit sampling, LSB first.
// rx_dv about 9.5 bit times + 2 clk after the start edge; no backpressure, so take rx_out on the pulse.
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_dv,
  output logic                  frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_out_q, rx_out_d;
  logic                  rx_dv_q, rx_dv_d;
  logic                  frame_err_q, frame_err_d;
  logic                  armed_q, armed_d;
  logic                  rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d     = rx_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_out_d    = rx_out_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
    armed_d     = armed_q;

    case (state_q)
      S_IDLE: begin
        // After a framing error the line must go high again before a new start counts.
        if (armed_q && !rx_s) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end else if (!armed_q && rx_s) begin
          armed_d = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == MID_START) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == MID_BIT) begin
            shift_d    = {rx_s, shift_q[DATA_WIDTH-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == MID_BIT) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (rx_s) begin
              rx_out_d = shift_q;
              rx_dv_d  = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_out_q    <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_out_q    <= rx_out_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  assign rx_out    = rx_out_q;
  assign rx_dv     = rx_dv_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: bench-driven serial frames against a queue of expected word/error events.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int DW       = 8;
  localparam int TICK_DIV = 27;   // 50 MHz / (115200 * 16)
  localparam int BIT_CLK  = 434;  // 8680 ns bit time at 20 ns clk

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic          rx_in;
  logic [DW-1:0] rx_out;
  logic          rx_dv;
  logic          frame_err;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_good;

  uart_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .rx_in     (rx_in),
    .rx_out    (rx_out),
    .rx_dv     (rx_dv),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  initial begin
    tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Model: a good stop bit delivers the byte; a bad one flags an error and leaves the last good word.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    ev_t e;
    e.is_err = !stop_ok;
    e.data   = stop_ok ? d : last_good;
    exp_q.push_back(e);
    if (stop_ok) last_good = d;
    rx_in = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx_in = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_in = stop_ok;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  initial begin
    bit  pdv = 1'b0;
    bit  pfe = 1'b0;
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rx_dv || frame_err) begin
        check("dv_fe_exclusive", {31'd0, rx_dv & frame_err}, 32'd0);
        check("pulse_one_clk", {31'd0, (rx_dv & pdv) | (frame_err & pfe)}, 32'd0);
        if ((rx_dv && !pdv) || (frame_err && !pfe)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: rx_dv=%0b frame_err=%0b rx_out=0x%0h, expected no pulse at %0t",
                     rx_dv, frame_err, rx_out, $time);
          end else begin
            e = exp_q.pop_front();
            check("event_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
            check("rx_out", {24'd0, rx_out}, {24'd0, e.data});
          end
        end
      end
      pdv = rx_dv;
      pfe = frame_err;
    end
  end

  initial begin
    logic [7:0] c3;
    logic [7:0] rnd;
    rst_n     = 1'b0;
    rx_in     = 1'b1;
    last_good = 8'h00;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_in = 1'($urandom_range(0, 1));
    end
    check("reset_rx_out", {24'd0, rx_out}, 32'd0);
    check("reset_rx_dv", {31'd0, rx_dv}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rx_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(3);

    send_frame(8'h55, 1'b1);
    idle_bits(1);

    send_frame(8'hF0, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);

    rx_in = 1'b0;
    repeat (100) @(negedge clk);
    idle_bits(2);
    send_frame(8'hA5, 1'b1);
    idle_bits(1);

    send_frame(8'h96, 1'b0);
    rx_in = 1'b0;
    repeat (2500) @(negedge clk);
    idle_bits(2);
    send_frame(8'h81, 1'b1);
    idle_bits(1);

    // Abort 0xC3 half way through data bit 4; reset also returns the line to idle.
    c3    = 8'hC3;
    rx_in = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = c3[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_in = c3[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst_n     = 1'b0;
    rx_in     = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    check("midframe_reset_rx_out", {24'd0, rx_out}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'h7E, 1'b1);
    idle_bits(1);

    for (int k = 0; k < 3; k++) begin
      rnd = 8'($urandom);
      send_frame(rnd, 1'b1);
      idle_bits($urandom_range(0, 2));
    end
    idle_bits(1);

    for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(negedge clk);
    check("pending_events", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
